// File: rtl/uart_rx_fifo.sv
// 8-N-1 UART receiver with first-word-fall-through receive FIFO.
// Flags stop-bit framing errors and sticky FIFO overrun.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 25000000,
  parameter int BIT_RATE   = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clear_overrun,
  output logic [7:0] rd_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CPB = CLOCK_FREQ / BIT_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] C_HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(CPB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_rxs;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_fe;
  logic          w_push;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          r_ovr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // Good stop bit: the assembled byte enters the FIFO on this same edge.
  assign w_push = (r_state == S_STOP) && (r_cnt == C_FULL) && w_rxs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_fe    <= 1'b0;
    end else begin
      r_fe <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_rxs ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_FULL) begin
            r_cnt   <= '0;
            r_shift <= {w_rxs, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_FULL) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_state <= S_IDLE;
            end else begin
              r_fe    <= 1'b1;
              r_state <= S_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = rd_en && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_drop)             r_ovr <= 1'b1;
      else if (clear_overrun) r_ovr <= 1'b0;
    end
  end

  assign rd_data     = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
  assign rx_empty    = w_empty;
  assign rx_full     = w_full;
  assign frame_error = r_fe;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames plus random traffic
// checked against a queue model of the receive FIFO.
module tb_uart_rx_fifo;

  localparam int CPB = 10;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] rd_data;
  logic       rx_empty;
  logic       rx_full;
  logic       frame_error;
  logic       overrun;

  int errs = 0;
  int checks = 0;
  int fe_cnt = 0;
  bit full_seen = 1'b0;

  logic [7:0] q[$];
  bit         m_ovr = 1'b0;

  uart_rx_fifo #(
    .CLOCK_FREQ(1000000),
    .BIT_RATE  (100000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .rx           (rx),
    .rd_en        (rd_en),
    .clear_overrun(clr),
    .rd_data      (rd_data),
    .rx_empty     (rx_empty),
    .rx_full      (rx_full),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_error) fe_cnt++;
    if (rx_full) full_seen = 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame vector is {stop, data[7:0], start}; one bit per CPB cycles.
  task automatic drive(input logic [9:0] fr, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      rx = fr[i / CPB];
      @(negedge clk);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  // Valid frame; optionally pops on the very edge the byte is pushed.
  task automatic send(input logic [7:0] b, input bit pop_at_push);
    drive({1'b1, b, 1'b0}, 97);
    if (pop_at_push) begin
      rd_en = 1'b1;
      if (q.size() > 0) chk("push_pop_data", rd_data, q[0]);
    end
    @(negedge clk);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    if (pop_at_push && q.size() > 0) void'(q.pop_front());
    model_push(b);
  endtask

  task automatic pop_chk(input string tag);
    if (q.size() > 0) begin
      chk(tag, rd_data, q[0]);
      void'(q.pop_front());
    end else begin
      chk({tag, "_empty"}, rx_empty, 1'b1);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clear_ovr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_ovr = 1'b0;
    chk("ovr_cleared", overrun, 1'b0);
  endtask

  initial begin
    int n;
    int r;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    chk("rst_empty", rx_empty, 1'b1);
    chk("rst_full", rx_full, 1'b0);
    chk("rst_fe", frame_error, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_data", rd_data, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte with exact push timing
    drive({1'b1, 8'hA5, 1'b0}, 97);
    chk("a5_empty_before", rx_empty, 1'b1);
    @(negedge clk);
    chk("a5_empty_after", rx_empty, 1'b0);
    chk("a5_data", rd_data, 8'hA5);
    q.push_back(8'hA5);
    repeat (2) @(negedge clk);
    pop_chk("a5_pop");
    chk("a5_drained", rx_empty, 1'b1);

    // Glitch shorter than half a bit
    fe_cnt = 0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_empty", rx_empty, 1'b1);
    chk("glitch_fe", fe_cnt, 0);

    // Framing error followed by a break
    fe_cnt = 0;
    drive({1'b0, 8'h3C, 1'b0}, 97);
    chk("fe_before", frame_error, 1'b0);
    @(negedge clk);
    chk("fe_pulse", frame_error, 1'b1);
    @(negedge clk);
    chk("fe_after", frame_error, 1'b0);
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("fe_count", fe_cnt, 1);
    chk("fe_empty", rx_empty, 1'b1);
    send(8'h81, 1'b0);
    pop_chk("fe_next_byte");

    // Fill and overrun
    for (int i = 0; i < 9; i++) begin
      send(8'(i), 1'b0);
      if (i == 7) begin
        chk("fill_full", rx_full, 1'b1);
        chk("fill_no_ovr", overrun, 1'b0);
      end
    end
    chk("fill_ovr", overrun, m_ovr);
    for (int i = 0; i < DEPTH; i++) pop_chk("fill_read");
    chk("fill_drained", rx_empty, 1'b1);
    clear_ovr();

    // Push while full with a same-cycle pop
    for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b0);
    chk("full_pre", rx_full, 1'b1);
    send(8'hE7, 1'b1);
    chk("full_pop_no_ovr", overrun, 1'b0);
    chk("full_pop_full", rx_full, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop_chk("full_pop_read");

    // Streaming with a pop on every push, wrapping the pointers
    full_seen = 1'b0;
    for (int i = 0; i < 20; i++) send(8'(8'h10 + i), 1'b1);
    chk("stream_one_left", q.size(), 1);
    pop_chk("stream_last");
    chk("stream_never_full", full_seen, 1'b0);
    chk("stream_empty", rx_empty, 1'b1);

    // Random traffic against the queue model
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        send(b, bit'($urandom_range(0, 1)));
      end
      chk("rnd_empty", rx_empty, q.size() == 0);
      chk("rnd_full", rx_full, q.size() == DEPTH);
      chk("rnd_ovr", overrun, m_ovr);
      r = $urandom_range(0, 5);
      for (int k = 0; k < r; k++) pop_chk("rnd_pop");
      if ($urandom_range(0, 3) == 0) clear_ovr();
    end
    while (q.size() > 0) pop_chk("rnd_drain");
    clear_ovr();

    // Reset during data bit 4, with a byte already queued
    send(8'h77, 1'b0);
    drive({1'b1, 8'hC3, 1'b0}, 52);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", rx_empty, 1'b1);
    chk("mid_rst_full", rx_full, 1'b0);
    chk("mid_rst_fe", frame_error, 1'b0);
    chk("mid_rst_ovr", overrun, 1'b0);
    chk("mid_rst_data", rd_data, 8'h00);
    q.delete();
    m_ovr = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    send(8'h5A, 1'b0);
    chk("post_rst_count", q.size(), 1);
    pop_chk("post_rst_5a");
    chk("post_rst_empty", rx_empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
